// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between the shared-bus devices and the arbiter.
interface bus_arbiter_if #(parameter int DEVICE_COUNT = 4);
    logic [DEVICE_COUNT-1:0] req;
    logic                    contention_in;
    logic                    err_clear;
    logic [DEVICE_COUNT-1:0] device_asserts_bar;
    logic [DEVICE_COUNT-1:0] grant;
    logic [3:0]              owner;
    logic                    busy;
    logic                    contention_error;
    modport master (
        input  req, contention_in, err_clear,
        output device_asserts_bar, grant, owner, busy, contention_error
    );
    modport slave (
        output req, contention_in, err_clear,
        input  device_asserts_bar, grant, owner, busy, contention_error
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for a shared bus, with dead turnaround cycles
// between owners, optional hold-time preemption and a sticky contention flag.
module bus_arbiter #(
    parameter int DEVICE_COUNT = 4,
    parameter int TURNAROUND   = 1,
    parameter int MAX_HOLD     = 0
) (
    input logic           clk,
    input logic           rst,
    bus_arbiter_if.master bus
);
    localparam int N  = DEVICE_COUNT;
    localparam int HW = $clog2(MAX_HOLD + 2);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t        r_state;
    logic [N-1:0]  r_grant;
    logic [3:0]    r_owner;
    logic [3:0]    r_ptr;
    logic          r_busy;
    logic          r_err;
    logic [2:0]    r_gap;
    logic [HW-1:0] r_hold;
    logic [N-1:0]  w_rot;
    logic [3:0]    w_off;
    logic [3:0]    w_sel;
    logic [4:0]    w_sum;
    logic          w_any;
    logic          w_arb;
    logic          w_release;

    // Rotate so bit 0 is the pointer position; the lowest set bit is the winner's offset.
    always_comb begin
        w_rot = N'({bus.req, bus.req} >> r_ptr);
        w_off = '0;
        for (int i = N - 1; i >= 0; i--)
            if (w_rot[i]) w_off = 4'(i);
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        w_sel = (w_sum >= 5'(N)) ? 4'(w_sum - 5'(N)) : w_sum[3:0];
    end

    assign w_any     = |bus.req;
    assign w_arb     = (r_state == IDLE) || (r_state == GAP && r_gap == 3'(TURNAROUND - 1));
    assign w_release = !(|(bus.req & r_grant)) ||
                       (MAX_HOLD > 0 && r_hold == HW'(MAX_HOLD - 1) && |(bus.req & ~r_grant));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
            r_gap   <= '0;
            r_hold  <= '0;
        end else if (w_arb) begin
            r_state <= w_any ? GRANT : IDLE;
            r_busy  <= w_any;
            r_grant <= w_any ? N'(1) << w_sel : '0;
            r_owner <= w_any ? w_sel : 4'd0;
            r_ptr   <= !w_any ? r_ptr : (w_sel == 4'(N - 1)) ? 4'd0 : w_sel + 4'd1;
            r_hold  <= '0;
        end else if (r_state == GAP) begin
            r_gap <= r_gap + 3'd1;
        end else begin
            r_hold <= (r_hold == HW'(MAX_HOLD)) ? r_hold : r_hold + HW'(1);
            if (w_release) begin
                r_state <= GAP;
                r_gap   <= '0;
                r_grant <= '0;
                r_owner <= '0;
            end
        end
    end

    // Set has priority over clear so a contention in the clearing cycle is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= bus.contention_in ? 1'b1 : bus.err_clear ? 1'b0 : r_err;
    end

    assign bus.grant              = r_grant;
    assign bus.device_asserts_bar = ~r_grant;
    assign bus.owner              = r_owner;
    assign bus.busy               = r_busy;
    assign bus.contention_error   = r_err;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks on three arbiter configurations sharing one clock and reset.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    bus_arbiter_if #(.DEVICE_COUNT(4)) a ();
    bus_arbiter_if #(.DEVICE_COUNT(4)) b ();
    bus_arbiter_if #(.DEVICE_COUNT(4)) c ();

    bus_arbiter #(.DEVICE_COUNT(4), .TURNAROUND(1), .MAX_HOLD(0)) u_a (.clk(clk), .rst(rst), .bus(a.master));
    bus_arbiter #(.DEVICE_COUNT(4), .TURNAROUND(1), .MAX_HOLD(4)) u_b (.clk(clk), .rst(rst), .bus(b.master));
    bus_arbiter #(.DEVICE_COUNT(4), .TURNAROUND(3), .MAX_HOLD(0)) u_c (.clk(clk), .rst(rst), .bus(c.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a.req = '0; a.contention_in = 1'b0; a.err_clear = 1'b0;
        b.req = '0; b.contention_in = 1'b0; b.err_clear = 1'b0;
        c.req = '0; c.contention_in = 1'b0; c.err_clear = 1'b0;
        tick;
        tick;
        chk("rst_bar", a.device_asserts_bar, 4'hf);
        chk("rst_grant", a.grant, 0);
        chk("rst_owner", a.owner, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_err", a.contention_error, 0);
        chk("rst_bar_c", c.device_asserts_bar, 4'hf);
        rst = 1'b0;

        // single requester holds three cycles, then one gap cycle, then idle
        a.req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("single_grant", a.grant, 4'b0001);
            chk("single_busy", a.busy, 1);
            if (i == 2) a.req = 4'b0000;
        end
        tick;
        chk("single_gap_bar", a.device_asserts_bar, 4'hf);
        chk("single_gap_busy", a.busy, 1);
        tick;
        chk("single_idle", a.busy, 0);
        chk("single_idle_bar", a.device_asserts_bar, 4'hf);

        // round robin from a freshly reset pointer
        rst = 1'b1;
        tick;
        rst = 1'b0;
        a.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            tick;
            chk("rr_grant", a.grant, 1 << (r % 4));
            chk("rr_owner", a.owner, r % 4);
            tick;
            chk("rr_hold", a.grant, 1 << (r % 4));
            a.req[r % 4] = 1'b0;
            tick;
            chk("rr_gap", a.device_asserts_bar, 4'hf);
            chk("rr_gap_owner", a.owner, 0);
            if (r == 4) a.req = 4'b0000;
            else a.req[r % 4] = 1'b1;
        end
        tick;
        chk("rr_idle", a.busy, 0);

        // hold limit of 4 alternates two persistent requesters
        b.req = 4'b0011;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick;
                chk("mh_grant", b.grant, (r == 1) ? 4'b0010 : 4'b0001);
            end
            if (r == 2) b.req = 4'b0000;
            tick;
            chk("mh_gap", b.device_asserts_bar, 4'hf);
        end
        tick;
        chk("mh_idle", b.busy, 0);

        // three-cycle turnaround
        c.req = 4'b0001;
        tick;
        chk("ta_grant0", c.grant, 4'b0001);
        c.req = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("ta_gap", c.device_asserts_bar, 4'hf);
            chk("ta_gap_grant", c.grant, 0);
        end
        tick;
        chk("ta_grant2", c.grant, 4'b0100);
        chk("ta_owner2", c.owner, 2);
        c.req = 4'b0000;
        for (int i = 0; i < 4; i++) tick;
        chk("ta_idle", c.busy, 0);

        // sticky contention flag
        a.contention_in = 1'b1;
        tick;
        a.contention_in = 1'b0;
        chk("cont_set", a.contention_error, 1);
        chk("cont_no_fsm", a.busy, 0);
        tick;
        tick;
        chk("cont_sticky", a.contention_error, 1);
        a.err_clear = 1'b1;
        tick;
        a.err_clear = 1'b0;
        chk("cont_clear", a.contention_error, 0);
        a.contention_in = 1'b1;
        tick;
        chk("cont_set2", a.contention_error, 1);
        a.err_clear = 1'b1;
        tick;
        a.contention_in = 1'b0;
        a.err_clear = 1'b0;
        chk("cont_set_wins", a.contention_error, 1);
        a.err_clear = 1'b1;
        tick;
        a.err_clear = 1'b0;
        chk("cont_clear2", a.contention_error, 0);

        // asynchronous reset in the middle of a grant
        a.req = 4'b0001;
        tick;
        chk("ar_grant", a.grant, 4'b0001);
        #2 rst = 1'b1;
        #1;
        chk("ar_bar", a.device_asserts_bar, 4'hf);
        chk("ar_grant0", a.grant, 0);
        chk("ar_busy", a.busy, 0);
        #1 rst = 1'b0;
        a.req = 4'b1000;
        tick;
        chk("ar_grant3", a.grant, 4'b1000);
        chk("ar_owner3", a.owner, 3);
        a.req = 4'b0000;
        tick;
        chk("ar_gap", a.device_asserts_bar, 4'hf);
        a.req = 4'b0110;
        tick;
        chk("ar_wrap", a.grant, 4'b0010);
        a.req = 4'b0000;
        tick;
        tick;
        chk("ar_idle", a.busy, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DEVICE_COUNT, default 4, number of devices sharing the bus (2..16).
REQ-002 SHALL have parameter TURNAROUND, default 1, number of dead cycles between bus owners (1..7).
REQ-003 SHALL have parameter MAX_HOLD, default 0, maximum consecutive owner cycles before preemption when others wait (0 = unlimited).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port req, input, DEVICE_COUNT, per-device bus request, level-held while the device wants the bus.
REQ-007 SHALL have port contention_in, input, 1, contention flag from the shared bus model.
REQ-008 SHALL have port err_clear, input, 1, synchronous clear of contention_error.
REQ-009 SHALL have port device_asserts_bar, output, DEVICE_COUNT, active-low per-device bus-drive enables.
REQ-010 SHALL have port grant, output, DEVICE_COUNT, active-high one-hot grant; always the bitwise inverse of device_asserts_bar.
REQ-011 SHALL have port owner, output, 4, index of the current owner; 0 when no device is granted.
REQ-012 SHALL have port busy, output, 1, high whenever the FSM is not IDLE.
REQ-013 SHALL have port contention_error, output, 1, sticky contention flag.

Function
REQ-014 SHALL implement FSM states IDLE, GRANT and GAP; all outputs registered.
REQ-015 In IDLE with any req bit high at edge t, SHALL enter GRANT, with the selected device's grant high and assert_bar low from edge t.
REQ-016 SHALL select round-robin: search starts at the priority pointer, ascending with wrap-around from DEVICE_COUNT-1 to 0.
REQ-017 Priority pointer SHALL reset to 0 and, on each grant to device k, become (k+1) mod DEVICE_COUNT.
REQ-018 In GRANT, the hold counter SHALL start at 0 on entry and increment each cycle, saturating at MAX_HOLD.
REQ-019 In GRANT, req[owner] sampled low SHALL cause entry to GAP on the next edge.
REQ-020 In GRANT with MAX_HOLD>0, hold counter = MAX_HOLD-1 and any other req bit high SHALL cause entry to GAP on the next edge, even if req[owner] is still high.
REQ-021 In GAP, all device_asserts_bar bits SHALL be 1, grant SHALL be 0 and owner SHALL be 0, for exactly TURNAROUND cycles.
REQ-022 On the last GAP cycle, SHALL arbitrate per REQ-016: any req high -> GRANT next edge; none -> IDLE.
REQ-023 At most one grant bit SHALL be high in any cycle; grant SHALL never pass directly between devices without a GAP.
REQ-024 A device that drops and re-raises req within GAP SHALL be treated as any other requester; no stored requests.
REQ-025 contention_in sampled high SHALL set contention_error on the next edge; the flag SHALL then hold until err_clear or rst.
REQ-026 When err_clear and contention_in are both high in the same cycle, contention_error SHALL set (set wins).
REQ-027 Contention SHALL NOT alter the FSM state or grants.

Reset
REQ-028 rst high SHALL asynchronously force IDLE, device_asserts_bar all ones, grant 0, owner 0, busy 0, contention_error 0, priority pointer 0 and counters 0.
REQ-029 Reset asserted during GRANT SHALL release the bus immediately, without waiting for a clock edge.
REQ-030 After rst deasserts, first arbitration SHALL occur at the first rising edge with rst low.

Verification
REQ-031 With N=4, T=1: req=0001 held 3 cycles then dropped -> grant=0001 for 3 cycles, then 1 GAP cycle with asserts_bar=1111, then IDLE.
REQ-032 With req=1111 held constant and each owner dropping req after 2 cycles and then re-raising it -> grant order 0,1,2,3,0, separated by GAP cycles.
REQ-033 With MAX_HOLD=4, req=0011 held -> device 0 granted 4 cycles, GAP, then device 1 granted 4 cycles, then device 0 again.
REQ-034 With T=3, owner releases while req=0100 -> exactly 3 cycles with asserts_bar=1111, then grant=0100.
REQ-035 contention_in pulsed one cycle -> contention_error=1 until err_clear; err_clear together with contention_in -> contention_error stays 1.
REQ-036 rst pulsed mid-GRANT between clock edges -> asserts_bar=1111 immediately; after release, req=1000 -> grant to device 3 (pointer back at 0).
